// File: rtl/bhand_arb.sv
// Packet-aware round-robin arbiter merging N_PORTS buffered-handshake streams into one
// registered output, with per-port wait counters that grant aging priority to starved ports.
module bhand_arb #(
    parameter int unsigned N_PORTS     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned AGE_LIMIT   = 8,
    localparam int unsigned PortW      = $clog2(N_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    in_data,
    input  logic [N_PORTS-1:0]               in_last,
    input  logic [N_PORTS-1:0]               in_vld,
    output logic [N_PORTS-1:0]               in_rdy,
    output logic [DATA_WIDTH-1:0]            odata,
    output logic                             olast,
    output logic [PortW-1:0]                 oport,
    output logic                             odata_vld,
    input  logic                             odata_rdy
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                                  state_q, state_d;
    logic [PortW-1:0]                        owner_q, owner_d;
    logic [PortW-1:0]                        rr_q, rr_d;
    logic [N_PORTS-1:0][COUNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                   odata_q, odata_d;
    logic                                    olast_q, olast_d;
    logic [PortW-1:0]                        oport_q, oport_d;
    logic                                    ovld_q, ovld_d;

    logic                                    load_ok;
    logic                                    age_hit, age_found, rr_hit;
    logic [COUNT_WIDTH-1:0]                  age_max;
    logic [PortW-1:0]                        age_idx, rr_idx;
    int unsigned                             idx;
    logic [PortW-1:0]                        grant;
    logic                                    grant_vld;
    logic                                    xfer;

    // Arbitration: owner while locked, else aging winner, else round-robin from rr_q.
    always_comb begin
        load_ok   = !ovld_q || odata_rdy;
        age_hit   = 1'b0;
        age_found = 1'b0;
        age_max   = '0;
        age_idx   = '0;
        rr_hit    = 1'b0;
        rr_idx    = '0;
        idx       = 0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (in_vld[i] && AGE_LIMIT != 0 && 32'(cnt_q[i]) >= AGE_LIMIT) begin
                age_hit = 1'b1;
            end
            if (in_vld[i] && (!age_found || cnt_q[i] > age_max)) begin
                age_found = 1'b1;
                age_max   = cnt_q[i];
                age_idx   = PortW'(i);
            end
        end
        for (int k = 0; k < int'(N_PORTS); k++) begin
            idx = 32'(rr_q) + 32'(k);
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!rr_hit && in_vld[idx]) begin
                rr_hit = 1'b1;
                rr_idx = PortW'(idx);
            end
        end

        grant     = '0;
        grant_vld = 1'b0;
        if (state_q == StLocked) begin
            grant     = owner_q;
            grant_vld = 1'b1;
        end else if (age_hit) begin
            grant     = age_idx;
            grant_vld = 1'b1;
        end else if (rr_hit) begin
            grant     = rr_idx;
            grant_vld = 1'b1;
        end

        in_rdy = '0;
        if (grant_vld && load_ok) begin
            in_rdy[grant] = 1'b1;
        end
        xfer = |(in_rdy & in_vld);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        odata_d = odata_q;
        olast_d = olast_q;
        oport_d = oport_q;
        ovld_d  = ovld_q;
        cnt_d   = cnt_q;

        if (xfer) begin
            odata_d = in_data[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
            olast_d = in_last[grant];
            oport_d = grant;
            ovld_d  = 1'b1;
            if (state_q == StIdle) begin
                rr_d = (32'(grant) == N_PORTS - 1) ? '0 : grant + PortW'(1);
                if (!in_last[grant]) begin
                    state_d = StLocked;
                    owner_d = grant;
                end
            end else if (in_last[grant]) begin
                state_d = StIdle;
            end
        end else if (ovld_q && odata_rdy) begin
            ovld_d = 1'b0;
        end

        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (in_vld[i] && in_rdy[i]) begin
                cnt_d[i] = '0;
            end else if (in_vld[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            odata_q <= '0;
            olast_q <= 1'b0;
            oport_q <= '0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            odata_q <= odata_d;
            olast_q <= olast_d;
            oport_q <= oport_d;
            ovld_q  <= ovld_d;
        end
    end

    assign odata     = odata_q;
    assign olast     = olast_q;
    assign oport     = oport_q;
    assign odata_vld = ovld_q;

endmodule

// File: tb/tb_bhand_arb.sv
// Directed self-checking bench for bhand_arb with default parameters (4 ports, AGE_LIMIT 8).
module tb_bhand_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_vld;
    logic [3:0]  in_rdy;
    logic [7:0]  odata;
    logic        olast;
    logic [1:0]  oport;
    logic        odata_vld;
    logic        odata_rdy;

    int checks   = 0;
    int failures = 0;

    bhand_arb dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .odata     (odata),
        .olast     (olast),
        .oport     (oport),
        .odata_vld (odata_vld),
        .odata_rdy (odata_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld  = '0;
        in_last = '0;
        in_data = '0;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        #1;
    endtask

    initial begin
        odata_rdy = 1'b1;
        do_reset();
        chk("rst_odata", 32'(odata), 0);
        chk("rst_olast", 32'(olast), 0);
        chk("rst_oport", 32'(oport), 0);
        chk("rst_vld", 32'(odata_vld), 0);
        chk("rst_in_rdy", 32'(in_rdy), 0);

        // Single-beat packet on port 2.
        in_vld = 4'b0100; in_last = 4'b0100; in_data = 32'h00A5_0000;
        #1 chk("p2_in_rdy", 32'(in_rdy), 32'h4);
        tick();
        chk("p2_odata", 32'(odata), 32'hA5);
        chk("p2_oport", 32'(oport), 2);
        chk("p2_olast", 32'(olast), 1);
        chk("p2_vld", 32'(odata_vld), 1);
        in_vld = '0;
        tick();
        chk("p2_drain", 32'(odata_vld), 0);

        // All ports hold single-beat packets: round robin 0,1,2,3,0.
        do_reset();
        in_vld = 4'b1111; in_last = 4'b1111; in_data = 32'h1312_1110;
        #1 chk("rr_first_rdy", 32'(in_rdy), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_oport", 32'(oport), 32'(k % 4));
            chk("rr_odata", 32'(odata), 32'h10 + 32'(k % 4));
            chk("rr_vld", 32'(odata_vld), 1);
        end
        in_vld = '0;
        tick();

        // Port 1 three-beat packet with a 2-cycle valid gap; port 0 must wait.
        do_reset();
        in_vld = 4'b0010; in_last = 4'b0000; in_data = 32'h0000_2100;
        #1 chk("lk_rdy0", 32'(in_rdy), 32'h2);
        tick();
        chk("lk_b1_oport", 32'(oport), 1);
        chk("lk_b1_odata", 32'(odata), 32'h21);
        in_vld = 4'b0001; in_last = 4'b0001; in_data = 32'h0000_2130;
        for (int k = 0; k < 2; k++) begin
            #1 chk("lk_gap_rdy", 32'(in_rdy), 32'h2);
            tick();
        end
        chk("lk_gap_drain", 32'(odata_vld), 0);
        chk("lk_gap_oport", 32'(oport), 1);
        in_vld = 4'b0011; in_data = 32'h0000_2230;
        #1 chk("lk_b2_rdy", 32'(in_rdy), 32'h2);
        tick();
        chk("lk_b2_odata", 32'(odata), 32'h22);
        chk("lk_b2_oport", 32'(oport), 1);
        in_last = 4'b0011; in_data = 32'h0000_2330;
        tick();
        chk("lk_b3_odata", 32'(odata), 32'h23);
        chk("lk_b3_olast", 32'(olast), 1);
        in_vld = 4'b0001;
        #1 chk("lk_p0_rdy", 32'(in_rdy), 32'h1);
        tick();
        chk("lk_p0_oport", 32'(oport), 0);
        chk("lk_p0_odata", 32'(odata), 32'h30);
        in_vld = '0;
        tick();

        // Backpressure for 5 cycles while port 1 waits.
        do_reset();
        odata_rdy = 1'b0;
        in_vld = 4'b0001; in_last = 4'b0011; in_data = 32'h0000_4140;
        #1 chk("bp_rdy0", 32'(in_rdy), 32'h1);
        tick();
        chk("bp_odata0", 32'(odata), 32'h40);
        in_vld = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_in_rdy", 32'(in_rdy), 0);
            tick();
            chk("bp_odata", 32'(odata), 32'h40);
            chk("bp_oport", 32'(oport), 0);
            chk("bp_vld", 32'(odata_vld), 1);
        end
        chk("bp_cnt1", 32'(dut.cnt_q[1]), 5);
        odata_rdy = 1'b1;
        #1 chk("bp_release_rdy", 32'(in_rdy), 32'h2);
        tick();
        chk("bp_p1_odata", 32'(odata), 32'h41);
        chk("bp_p1_oport", 32'(oport), 1);
        chk("bp_cnt1_clr", 32'(dut.cnt_q[1]), 0);
        in_vld = '0;
        tick();

        // Aging: port 3 starves 9 cycles behind a long port-0 packet.
        do_reset();
        in_vld = 4'b0001; in_last = 4'b1110; in_data = 32'h7362_5150;
        tick();
        for (int n = 2; n <= 10; n++) begin
            in_vld = (n >= 5) ? 4'b1111 : 4'b1001;
            in_last[0] = (n == 10);
            #1 chk("age_lock_rdy", 32'(in_rdy), 32'h1);
            tick();
            chk("age_lock_oport", 32'(oport), 0);
        end
        chk("age_cnt3", 32'(dut.cnt_q[3]), 9);
        in_vld = 4'b1110;
        #1 chk("age_win_rdy", 32'(in_rdy), 32'h8);
        tick();
        chk("age_win_oport", 32'(oport), 3);
        chk("age_win_odata", 32'(odata), 32'h73);
        in_vld = 4'b0110;
        #1 chk("age_next_rr", 32'(in_rdy), 32'h2);
        tick();
        chk("age_next_oport", 32'(oport), 1);
        in_vld = '0;
        tick();

        // Reset asserted mid-packet.
        do_reset();
        in_vld = 4'b0100; in_last = 4'b0000; in_data = 32'h0090_0080;
        tick();
        chk("mr_oport", 32'(oport), 2);
        in_vld = 4'b0101;
        rst = 1'b1;
        #1 chk("mr_vld", 32'(odata_vld), 0);
        chk("mr_oport_rst", 32'(oport), 0);
        tick();
        rst = 1'b0;
        #1 chk("mr_rr_rdy", 32'(in_rdy), 32'h1);
        tick();
        chk("mr_after_oport", 32'(oport), 0);
        chk("mr_after_odata", 32'(odata), 32'h80);
        in_vld = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bhand_arb.md
# bhand_arb

Packet-aware round-robin arbiter that merges N_PORTS buffered-handshake streams into one registered output stream. It sits upstream of a `bhand` stage, which it feeds from several producers such as per-channel snoop buffers. Ownership is held for the whole packet, from the first granted beat through the beat with `in_last`. A per-port starvation counter overrides the round-robin order when a waiting port exceeds an age limit.

## Interface
- `N_PORTS`, 4: number of requesters; must be ≥2.
- `DATA_WIDTH`, 8: payload width per port.
- `COUNT_WIDTH`, 4: width of each per-port wait counter.
- `AGE_LIMIT`, 8: wait count at which aging priority applies. A value of 0 disables aging. Must be ≤2^COUNT_WIDTH−1.

Ports:
- `clk`, input, 1 bit: the block's single clock.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `in_data`, input, N_PORTS*DATA_WIDTH bits: port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_last`, input, N_PORTS bits: last beat of the packet, per port.
- `in_vld`, input, N_PORTS bits: per-port valid.
- `in_rdy`, output, N_PORTS bits: per-port ready. At most one bit is high in any cycle.
- `odata`, output, DATA_WIDTH bits: registered payload.
- `olast`, output, 1 bit: registered last flag.
- `oport`, output, $clog2(N_PORTS) bits: index of the source port of the current output beat.
- `odata_vld`, output, 1 bit: output valid.
- `odata_rdy`, input, 1 bit: output ready.

## Operation
- Handshake rule on every interface: a transfer occurs on a cycle where vld && rdy. A source must hold `vld` and data stable until the transfer completes.
- Output register load condition: `load_ok = !odata_vld || odata_rdy`. `in_rdy[g]` = `load_ok` && (g is the current grant).
- Output register on an input transfer: captures `in_data[g]`, `in_last[g]` and g, and sets `odata_vld`=1.
- Output register otherwise: if odata_vld && odata_rdy, clears `odata_vld`. The data fields hold their last value.
- State IDLE: the grant is chosen combinationally from `in_vld`.
  - Aging path: taken when AGE_LIMIT≠0 and some valid port has wait_cnt ≥ AGE_LIMIT. The grant is the valid port with the largest wait_cnt; ties go to the lowest index.
  - Round-robin path, otherwise: the grant is the first valid port searching upward from `rr_ptr`, wrapping from N_PORTS−1 to 0.
  - No valid port: no grant, so `in_rdy`=0.
- IDLE on a granted transfer: `rr_ptr` ← (g+1) mod N_PORTS. If `in_last[g]`=0, state ← LOCKED with owner=g. If `in_last[g]`=1 (single-beat packet), state stays IDLE.
- State LOCKED: the grant is the owner only. Other ports see `in_rdy`=0 even while the owner is idle, which produces bubbles. A transfer with `in_last[owner]`=1 returns the state to IDLE.
- Wait counter, per port i, checked in priority order each cycle:
  1. Port i transfers: cleared to 0.
  2. `in_vld[i]`=1 and port i did not transfer: incremented, saturating at 2^COUNT_WIDTH−1.
  3. Neither: held.
- Arithmetic: the counter must not wrap. `rr_ptr` uses modulo N_PORTS wrap even when N_PORTS is not a power of two.
- `in_rdy` depends combinationally on `in_vld` and `odata_rdy`. There is no combinational path from `in_data` to any output.

## Timing
- Reset values, applied asynchronously: `odata`=0, `olast`=0, `oport`=0, `odata_vld`=0; `in_rdy`=0 until any `in_vld` is seen after reset; state=IDLE, `rr_ptr`=0, all wait counters 0.
- Reset asserted mid-packet drops ownership. The partially forwarded packet is not completed, and the first grant after reset follows IDLE rules.
- Latency: an input transfer in cycle t gives `odata_vld`=1 in cycle t+1.
- Throughput: 1 beat/cycle while `odata_rdy`=1 and the granted port is valid.
- Back-to-back packets from different ports have no bubble. Port A's last beat transfers in cycle t, and port B can transfer in cycle t+1.
- Backpressure: when `odata_rdy`=0 and `odata_vld`=1, all `in_rdy` are 0. The grant, state, `rr_ptr` and owner hold; wait counters of valid ports keep incrementing.
- Grant changes take effect only at IDLE arbitration points. A new `in_vld` arriving during LOCKED never changes `oport` mid-packet.

## Test plan
- Reset → all outputs 0, `in_rdy`=0. Then `in_vld`=4'b0100 with `in_last`=1 and data 8'hA5 → `in_rdy`=4'b0100 in the same cycle; `odata`=8'hA5, `oport`=2, `olast`=1 one cycle later.
- All 4 ports hold valid single-beat packets, `odata_rdy`=1 → `oport` sequence 0,1,2,3,0,… with one beat per cycle and no bubbles.
- Port 1 sends a 3-beat packet while port 0 is also valid → `oport`=1,1,1, then 0. Also insert a 2-cycle gap in port 1's valid mid-packet → `in_rdy[0]` stays 0 during the gap.
- `odata_rdy`=0 for 5 cycles with the output full → `odata` and `oport` stable, all `in_rdy`=0, and the waiting port's wait_cnt rises by 5.
- AGE_LIMIT=8: port 0 streams one long packet while port 3 waits for 9 cycles, with ports 1 and 2 also valid and `rr_ptr`=1 → at the IDLE point after port 0's last beat, port 3 wins over the round-robin pick.
- Assert `rst` mid-packet for one cycle → `odata_vld`=0 immediately, state=IDLE, and the next grant follows round-robin from 0.
